// File: rtl/regfile_wb_sched.sv
// -----------------------------------------------------------------------------
// regfile_wb_sched
//   Write-port scheduler and busy scoreboard for an 8 x 32 register file.
//   Two writeback sources (A = ALU, B = load unit) share the single write port
//   through a round-robin arbiter and one registered output stage. An 8-bit
//   scoreboard tracks registers with a write in flight and stalls issue on
//   RAW and WAW hazards.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   iss_valid, iss_dst,
//   iss_src1, iss_src2            issuing instruction
//   iss_ready                     issue may complete this cycle
//   a_valid/a_dst/a_data          writeback request from source A
//   b_valid/b_dst/b_data          writeback request from source B
//   a_ready, b_ready              grant (handshake completes this cycle)
//   rf_in, rf_w, rf_we            register file write port
//   busy                          scoreboard, bit i = write to r[i] pending
//   wb_err                        sticky protocol error flag
// -----------------------------------------------------------------------------
module regfile_wb_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iss_valid,
  input  logic [2:0]  iss_dst,
  input  logic [2:0]  iss_src1,
  input  logic [2:0]  iss_src2,
  output logic        iss_ready,
  input  logic        a_valid,
  input  logic [2:0]  a_dst,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  input  logic [2:0]  b_dst,
  input  logic [31:0] b_data,
  output logic        a_ready,
  output logic        b_ready,
  output logic [31:0] rf_in,
  output logic [2:0]  rf_w,
  output logic        rf_we,
  output logic [7:0]  busy,
  output logic        wb_err
);

  // Arbiter priority: which source wins when both request.
  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

  logic        prio;
  logic        gnt;
  logic [2:0]  gnt_dst;
  logic [31:0] gnt_data;
  logic        issue;
  logic        commit_hit;
  logic        spurious;
  logic        collide;
  logic [7:0]  busy_nxt;

  // Issue is gated on registered busy only; a commit in the same cycle is
  // not bypassed, so the dependent instruction waits one more cycle.
  assign iss_ready = ~busy[iss_src1] & ~busy[iss_src2] & ~busy[iss_dst];
  assign issue     = iss_valid & iss_ready;

  // A wins when alone or when it holds priority; B wins otherwise.
  assign a_ready  = a_valid & (~b_valid | (prio == PRIO_A));
  assign b_ready  = b_valid & ~a_ready;
  assign gnt      = a_ready | b_ready;
  assign gnt_dst  = a_ready ? a_dst  : b_dst;
  assign gnt_data = a_ready ? a_data : b_data;

  // A grant to a register whose previous write is committing right now is
  // legitimate even though nothing re-marked it busy in between.
  assign commit_hit = rf_we & (rf_w == gnt_dst);
  assign spurious   = gnt & ~busy[gnt_dst] & ~commit_hit;
  assign collide    = a_valid & b_valid & (a_dst == b_dst);

  // Commit clears and issue sets; they never target the same bit in the
  // same cycle because a busy destination blocks issue.
  always_comb begin
    // NOTE: default assignment first so every path drives busy_nxt and no latch is inferred.
    busy_nxt = busy;
    if (rf_we) busy_nxt[rf_w]    = 1'b0;
    if (issue) busy_nxt[iss_dst] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= '0;
      prio   <= PRIO_A;
      rf_we  <= 1'b0;
      rf_in  <= '0;
      rf_w   <= '0;
      wb_err <= 1'b0;
    end else begin
      busy  <= busy_nxt;
      rf_we <= gnt;
      if (gnt) begin
        rf_in <= gnt_data;
        rf_w  <= gnt_dst;
        // Priority passes to the source that was not served.
        prio  <= a_ready ? PRIO_B : PRIO_A;
      end
      if (spurious || collide) wb_err <= 1'b1;
    end
  end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-port scheduler and scoreboard for the 8-entry × 32-bit register file (one write port, two read ports). Two writeback sources share the single write port: A is the ALU and B is the load unit. The block arbitrates them round-robin through one output pipeline stage and tracks pending destinations in an 8-bit busy scoreboard. It sits between issue/writeback and the register file, and stalls issue on RAW and WAW hazards.

## Interface
- No parameters; widths fixed: data 32, register index 3, 8 registers.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- iss_valid  in  1  issue slot presents an instruction
- iss_dst  in  3  destination register of issuing instruction
- iss_src1, iss_src2  in  3  source registers of issuing instruction
- iss_ready  out  1  issue accepted this cycle when iss_valid & iss_ready
- a_valid, b_valid  in  1  writeback request from source A / B
- a_dst, b_dst  in  3  writeback destination
- a_data, b_data  in  32  writeback data
- a_ready, b_ready  out  1  request granted (handshake completes this cycle)
- rf_in  out  32  register file write data
- rf_w  out  3  register file write index
- rf_we  out  1  register file write enable
- busy  out  8  scoreboard, bit i = write to register i pending
- wb_err  out  1  sticky error flag

## Operation
- Scoreboard: busy[iss_dst] is set at the edge of an issue handshake. busy[rf_w] is cleared at the edge where rf_we=1 (commit).
- iss_ready = !busy[iss_src1] & !busy[iss_src2] & !busy[iss_dst]. It is combinational from registered busy only; there is no same-cycle bypass of a commit.
- Arbiter: a 1-bit prio register; 0 = A preferred.
  - Only one valid: that source is granted.
  - Both valid: the prio source is granted.
  - After any grant, prio <= the non-granted source index (grant A → prio=1, grant B → prio=0).
  - prio is unchanged when no grant occurs.
- a_ready / b_ready equal the grant. They are combinational from valids and prio, and at most one is high. The write port never back-pressures.
- Output stage: on a grant, rf_in/rf_w are loaded from the granted source's data/dst and rf_we <= 1. Otherwise rf_we <= 0 and rf_in/rf_w hold their values.
- Issue and commit to the same register in the same cycle cannot happen: a busy dst blocks issue. Set-then-clear ordering is therefore not needed. A commit clears the bit; an issue on a different bit sets it, and both apply on the same edge.
- wb_err is set, and held until reset, on either of:
  - a grant whose dst is not busy and is not rf_w with rf_we=1 (spurious writeback); the write still proceeds;
  - a_valid & b_valid with a_dst == b_dst.

## Timing
- Reset (async assert, sync release) clears: busy=0, prio=0, rf_we=0, rf_in=0, rf_w=0, wb_err=0. iss_ready then follows the sources (1 when busy=0). a_ready and b_ready follow the valids.
- Writeback latency:
  - grant at edge N → rf_we=1 during cycle N..N+1;
  - register file written at edge N+1, with busy bit clearing on the same edge;
  - a dependent instruction sees iss_ready=1 in cycle N+1 and can issue at edge N+2.
- Throughput: one write per cycle. With A and B both continuously valid, grants alternate A,B,A,B starting from the current prio.
- A reset mid-operation drops the in-flight rf_we. Pending busy bits are lost; upstream is reset together with this block.

## Test plan
- Reset: hold rst_n=0 with random inputs → rf_we=0, busy=0, wb_err=0, a_ready=a_valid (prio A). Release, issue dst=3 → busy=8'h08 next cycle.
- RAW stall: issue dst=5 at edge 1; present src1=5 → iss_ready=0. A writes r5=32'hDEADBEEF at edge 3 → rf_we=1, rf_w=5, rf_in=DEADBEEF in cycle 3–4. busy[5] clears at edge 4, and iss_ready=1 in the following cycle.
- Round-robin: issue r1, r2, r3, r4. Hold A and B valid for 4 cycles → grant order A,B,A,B; rf_w sequence matches; busy=0 after final commit.
- Single source: only B valid for 3 cycles → B granted each cycle. Then both valid → prio=0, so A is granted first.
- WAW stall: r6 busy, issue with iss_dst=6 and free sources → iss_ready=0 until commit of r6.
- Errors:
  - writeback to non-busy r7 → write occurs and wb_err=1, sticky until rst_n low;
  - after reset, a_dst=b_dst=2, both valid → wb_err=1.
